// File: rtl/fir_stimulus_gen_if.sv
// Sample stream from the stimulus generator into the FIR under test.
// The master drives result/result_valid; the slave returns result_ready.
interface fir_stimulus_gen_if #(
  parameter int unsigned DATA_W = 16
);
  logic [DATA_W-1:0] result;
  logic              result_valid;
  logic              result_ready;

  modport master (output result, output result_valid, input result_ready);
  modport slave  (input result, input result_valid, output result_ready);
endinterface

// File: rtl/fir_stimulus_gen.sv
// Run-time configurable stimulus source for the FIR harness: impulse, step, ramp,
// square or LFSR samples, paced by a divider and streamed over valid/ready.
module fir_stimulus_gen #(
  parameter int unsigned       DATA_W    = 16,
  parameter int unsigned       DIV_W     = 8,
  parameter int unsigned       LEN_W     = 16,
  parameter logic [DATA_W-1:0] LFSR_SEED = 16'hACE1,
  parameter logic [DATA_W-1:0] LFSR_TAPS = 16'hB400
) (
  input  logic                system1000,
  input  logic                system1000_rst,
  input  logic                start,
  input  logic                abort,
  input  logic [2:0]          mode,
  input  logic [DATA_W-1:0]   amplitude,
  input  logic [LEN_W-1:0]    half_period,
  input  logic [DIV_W-1:0]    rate_div,
  input  logic [LEN_W-1:0]    length,
  fir_stimulus_gen_if.master  out_if,
  output logic                busy,
  output logic                done
);

  typedef enum logic [1:0] {StIdle, StPace, StPresent, StDone} state_e;

  localparam logic [DATA_W-1:0] MinVal = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] MaxVal = {1'b0, {(DATA_W-1){1'b1}}};

  state_e            state_q, state_d;
  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic [LEN_W-1:0]  n_q, n_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [LEN_W-1:0]  phase_q, phase_d;
  logic              neg_q, neg_d;
  logic [DATA_W-1:0] lfsr_q, lfsr_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [2:0]        mode_q, mode_d;
  logic [DATA_W-1:0] amp_q, amp_d;
  logic [LEN_W-1:0]  half_q, half_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [LEN_W-1:0]  len_q, len_d;

  logic              xfer;
  logic              last;
  logic [LEN_W-1:0]  half_eff;
  logic [LEN_W-1:0]  n_adv;
  logic [DATA_W-1:0] acc_adv;
  logic [LEN_W-1:0]  phase_adv;
  logic              neg_adv;
  logic [DATA_W-1:0] lfsr_adv;
  logic [DATA_W-1:0] amp_neg;

  function automatic logic [DATA_W-1:0] sample_f(
    input logic [2:0]        md,
    input logic [DATA_W-1:0] amp,
    input logic [DATA_W-1:0] amp_n,
    input logic [LEN_W-1:0]  n,
    input logic [DATA_W-1:0] acc,
    input logic              neg,
    input logic [DATA_W-1:0] lf
  );
    logic [DATA_W-1:0] s;
    case (md)
      3'd0:    s = (n == '0) ? amp : '0;
      3'd1:    s = amp;
      3'd2:    s = acc;
      3'd3:    s = neg ? amp_n : amp;
      3'd4:    s = lf;
      default: s = '0;
    endcase
    return s;
  endfunction

  always_comb begin
    xfer      = valid_q & out_if.result_ready;
    half_eff  = (half_q == '0) ? LEN_W'(1) : half_q;
    n_adv     = n_q + LEN_W'(1);
    acc_adv   = acc_q + amp_q;
    lfsr_adv  = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : '0);
    // Negating the most negative value would wrap back to itself, so clamp it.
    amp_neg   = (amp_q == MinVal) ? MaxVal : (~amp_q + DATA_W'(1));
    if (phase_q == half_eff - LEN_W'(1)) begin
      phase_adv = '0;
      neg_adv   = ~neg_q;
    end else begin
      phase_adv = phase_q + LEN_W'(1);
      neg_adv   = neg_q;
    end
    last = (len_q != '0) && (n_adv == len_q);

    state_d  = state_q;
    cnt_d    = cnt_q;
    n_d      = n_q;
    acc_d    = acc_q;
    phase_d  = phase_q;
    neg_d    = neg_q;
    lfsr_d   = lfsr_q;
    result_d = result_q;
    valid_d  = valid_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    mode_d   = mode_q;
    amp_d    = amp_q;
    half_d   = half_q;
    div_d    = div_q;
    len_d    = len_q;

    case (state_q)
      StIdle: begin
        if (start && !abort) begin
          mode_d  = mode;
          amp_d   = amplitude;
          half_d  = half_period;
          div_d   = rate_div;
          len_d   = length;
          n_d     = '0;
          acc_d   = '0;
          phase_d = '0;
          neg_d   = 1'b0;
          lfsr_d  = LFSR_SEED;
          cnt_d   = rate_div;
          busy_d  = 1'b1;
          state_d = StPace;
        end
      end
      StPace: begin
        if (cnt_q == '0) begin
          result_d = sample_f(mode_q, amp_q, amp_neg, n_q, acc_q, neg_q, lfsr_q);
          valid_d  = 1'b1;
          state_d  = StPresent;
        end else begin
          cnt_d = cnt_q - DIV_W'(1);
        end
      end
      StPresent: begin
        if (xfer) begin
          n_d     = n_adv;
          acc_d   = acc_adv;
          phase_d = phase_adv;
          neg_d   = neg_adv;
          lfsr_d  = lfsr_adv;
          if (last) begin
            valid_d = 1'b0;
            done_d  = 1'b1;
            state_d = StDone;
          end else if (div_q == '0) begin
            // Back-to-back: next sample replaces the current one on the same edge.
            result_d = sample_f(mode_q, amp_q, amp_neg, n_adv, acc_adv, neg_adv, lfsr_adv);
          end else begin
            valid_d = 1'b0;
            cnt_d   = div_q - DIV_W'(1);
            state_d = StPace;
          end
        end
      end
      StDone: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (abort) begin
      state_d = StIdle;
      valid_d = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge system1000 or posedge system1000_rst) begin
    if (system1000_rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      n_q      <= '0;
      acc_q    <= '0;
      phase_q  <= '0;
      neg_q    <= 1'b0;
      lfsr_q   <= LFSR_SEED;
      result_q <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      mode_q   <= '0;
      amp_q    <= '0;
      half_q   <= '0;
      div_q    <= '0;
      len_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      n_q      <= n_d;
      acc_q    <= acc_d;
      phase_q  <= phase_d;
      neg_q    <= neg_d;
      lfsr_q   <= lfsr_d;
      result_q <= result_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      mode_q   <= mode_d;
      amp_q    <= amp_d;
      half_q   <= half_d;
      div_q    <= div_d;
      len_q    <= len_d;
    end
  end

  assign out_if.result       = result_q;
  assign out_if.result_valid = valid_q;
  assign busy                = busy_q;
  assign done                = done_q;

endmodule

// File: tb/tb_fir_stimulus_gen.sv
// Randomised and directed bench for fir_stimulus_gen against a per-index sample model
// and a cycle-level pacing expectation.
module tb_fir_stimulus_gen;
  localparam int DW = 16;
  localparam int LW = 16;
  localparam int VW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start, abort;
  logic [2:0]    mode;
  logic [DW-1:0] amplitude;
  logic [LW-1:0] half_period;
  logic [VW-1:0] rate_div;
  logic [LW-1:0] length;
  logic          busy, done;

  int errors = 0;
  int checks = 0;
  logic [DW-1:0] got_q[$];

  fir_stimulus_gen_if #(.DATA_W(DW)) res_if ();

  fir_stimulus_gen dut (
    .system1000    (clk),
    .system1000_rst(rst),
    .start         (start),
    .abort         (abort),
    .mode          (mode),
    .amplitude     (amplitude),
    .half_period   (half_period),
    .rate_div      (rate_div),
    .length        (length),
    .out_if        (res_if),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] lfsr_at(input int idx);
    logic [DW-1:0] s = 16'hACE1;
    for (int i = 0; i < idx; i++) begin
      if (s[0]) s = (s >> 1) ^ 16'hB400;
      else      s = s >> 1;
    end
    return s;
  endfunction

  // Sample value as a direct function of the index and the burst configuration.
  function automatic logic [DW-1:0] model_sample(input int md, input logic [DW-1:0] amp,
                                                 input int half, input int idx);
    logic [31:0]   p;
    logic [DW-1:0] ng;
    int            h;
    h  = (half == 0) ? 1 : half;
    ng = (amp == 16'h8000) ? 16'h7FFF : -amp;
    p  = idx * amp;
    case (md)
      0:       return (idx == 0) ? amp : '0;
      1:       return amp;
      2:       return p[DW-1:0];
      3:       return (((idx / h) % 2) == 1) ? ng : amp;
      4:       return lfsr_at(idx);
      default: return '0;
    endcase
  endfunction

  // rmode: 0 ready high, 1 random ready, 2 ready low on cycles 6..15 only.
  task automatic run_burst(input int md, input logic [DW-1:0] amp, input int half, input int rd,
                           input int len, input int rmode, input int n_cont, input bit poke);
    int  idx = 0;
    int  due;
    int  e = 0;
    bit  pres = 1'b0;
    bit  xfer;
    bit  fin = 1'b0;
    got_q.delete();
    mode        = 3'(md);
    amplitude   = amp;
    half_period = LW'(half);
    rate_div    = VW'(rd);
    length      = LW'(len);
    start       = 1'b1;
    step();
    start       = 1'b0;
    mode        = 3'($urandom);
    amplitude   = DW'($urandom);
    half_period = LW'($urandom);
    rate_div    = VW'($urandom);
    length      = LW'($urandom);
    check_eq("busy_after_start", busy, 1);
    due = rd + 1;
    while (!fin && e < 3000) begin
      e++;
      case (rmode)
        0:       res_if.result_ready = 1'b1;
        1:       res_if.result_ready = ($urandom_range(0, 3) != 0);
        default: res_if.result_ready = !(e >= 6 && e <= 15);
      endcase
      start = poke && (idx == 2);
      xfer  = res_if.result_valid && res_if.result_ready;
      step();
      start = 1'b0;
      if (xfer) begin
        got_q.push_back(res_if.result_valid ? 16'h0 : 16'h0);
        idx++;
        pres = 1'b0;
        due  = e + rd;
        if (len != 0 && idx == len) begin
          check_eq("done_pulse", done, 1);
          check_eq("valid_at_done", res_if.result_valid, 0);
          check_eq("busy_at_done", busy, 1);
          step();
          check_eq("done_cleared", done, 0);
          check_eq("busy_cleared", busy, 0);
          check_eq("valid_idle", res_if.result_valid, 0);
          fin = 1'b1;
        end else if (len == 0 && idx == n_cont) begin
          abort = 1'b1;
          step();
          abort = 1'b0;
          check_eq("abort_valid", res_if.result_valid, 0);
          check_eq("abort_busy", busy, 0);
          check_eq("abort_done", done, 0);
          for (int i = 0; i < 3; i++) begin
            step();
            check_eq("no_done_after_abort", done, 0);
          end
          fin = 1'b1;
        end
      end
      if (!fin) begin
        if (!pres && e == due) pres = 1'b1;
        check_eq("valid_timing", res_if.result_valid, 32'(pres));
        if (pres) check_eq("sample", res_if.result, model_sample(md, amp, half, idx));
        check_eq("done_low", done, 0);
        check_eq("busy_high", busy, 1);
      end
    end
    check_eq("burst_timeout", 32'(fin), 1);
  endtask

  // Captured samples are stored separately so directed checks compare the DUT to literals.
  logic [DW-1:0] cap_q[$];
  always @(posedge clk) begin
    if (!rst && res_if.result_valid && res_if.result_ready) cap_q.push_back(res_if.result);
  end

  initial begin
    int md, rd, half, len, ncont;
    int wait_cnt;
    rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    mode = '0;
    amplitude = '0;
    half_period = '0;
    rate_div = '0;
    length = '0;
    res_if.result_ready = 1'b0;
    repeat (2) step();
    check_eq("rst_result", res_if.result, 0);
    check_eq("rst_valid", res_if.result_valid, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    rst = 1'b0;
    step();

    cap_q.delete();
    run_burst(0, 16'd100, 0, 0, 4, 0, 0, 1'b0);
    check_eq("impulse_count", cap_q.size(), 4);
    if (cap_q.size() == 4) begin
      check_eq("impulse_s0", cap_q[0], 100);
      check_eq("impulse_s1", cap_q[1], 0);
      check_eq("impulse_s3", cap_q[3], 0);
    end

    cap_q.delete();
    run_burst(2, 16'h4000, 0, 0, 4, 0, 0, 1'b0);
    if (cap_q.size() == 4) check_eq("ramp_wrap", cap_q[3], 16'hC000);
    else check_eq("ramp_count", cap_q.size(), 4);

    cap_q.delete();
    run_burst(3, 16'd1000, 2, 0, 6, 0, 0, 1'b0);
    if (cap_q.size() == 6) check_eq("square_neg", cap_q[2], 16'hFC18);
    else check_eq("square_count", cap_q.size(), 6);

    cap_q.delete();
    run_burst(3, 16'h8000, 2, 0, 4, 0, 0, 1'b0);
    if (cap_q.size() == 4) check_eq("square_sat", cap_q[2], 16'h7FFF);
    else check_eq("square_sat_count", cap_q.size(), 4);

    run_burst(1, 16'd7, 0, 3, 6, 2, 0, 1'b0);

    cap_q.delete();
    run_burst(4, 16'd0, 0, 0, 0, 0, 20, 1'b1);
    if (cap_q.size() >= 2) begin
      check_eq("lfsr_s0", cap_q[0], 16'hACE1);
      check_eq("lfsr_s1", cap_q[1], 16'hE270);
    end else check_eq("lfsr_count", cap_q.size(), 20);

    run_burst(6, 16'h1234, 0, 1, 3, 0, 0, 1'b0);

    start = 1'b1;
    abort = 1'b1;
    mode  = 3'd1;
    step();
    start = 1'b0;
    abort = 1'b0;
    check_eq("abort_beats_start", busy, 0);
    repeat (3) step();
    check_eq("abort_beats_start_valid", res_if.result_valid, 0);

    for (int t = 0; t < 40; t++) begin
      md    = $urandom_range(0, 7);
      rd    = $urandom_range(0, 3);
      half  = $urandom_range(0, 3);
      len   = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 8);
      ncont = $urandom_range(5, 12);
      run_burst(md, DW'($urandom), half, rd, len, 1, ncont, t[0]);
    end

    mode = 3'd4;
    rate_div = '0;
    length = '0;
    start = 1'b1;
    step();
    start = 1'b0;
    res_if.result_ready = 1'b0;
    wait_cnt = 0;
    while (!res_if.result_valid && wait_cnt < 20) begin
      step();
      wait_cnt++;
    end
    check_eq("pre_reset_valid", res_if.result_valid, 1);
    #2 rst = 1'b1;
    #1;
    check_eq("async_rst_result", res_if.result, 0);
    check_eq("async_rst_valid", res_if.result_valid, 0);
    check_eq("async_rst_busy", busy, 0);
    step();
    rst = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
